// File: rtl/alu_seq_ctl.sv
// alu_seq_ctl: multi-cycle sequencer placed between instruction decode and
// the execute datapath (ALU, multiplier, serial shifter). One R-type op is
// accepted per start pulse, and the sequencer drives the control code, the
// operand load, the per-bit step and the result write strobes until the op
// retires.
module alu_seq_ctl #(
    parameter int MUL_STEPS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    output logic [5:0] ctl,
    output logic       busy,
    output logic       load,
    output logic       step,
    output logic       rd_we,
    output logic       hilo_we,
    output logic       done,
    output logic       illegal
);

    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;

    // The multiplier counts down to zero, so it starts one below the step count.
    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_SHIFT,
        S_WB
    } state_t;

    state_t     state, state_n;
    logic [5:0] op_r, op_n;
    logic [4:0] cnt, cnt_n;
    logic       illegal_r, illegal_n;

    function automatic logic is_legal(input logic [5:0] f);
        is_legal = (f == F_AND) || (f == F_OR)  || (f == F_ADD) ||
                   (f == F_SUB) || (f == F_SLT) || (f == F_SRL) ||
                   (f == F_MULTU);
    endfunction

    // State, captured op, step counter and illegal pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_r      <= 6'd0;
            cnt       <= 5'd0;
            illegal_r <= 1'b0;
        end else begin
            state     <= state_n;
            op_r      <= op_n;
            cnt       <= cnt_n;
            illegal_r <= illegal_n;
        end
    end

    // Next-state, counter sequencing and strobe decode from the current state.
    always_comb begin
        state_n   = state;
        op_n      = op_r;
        cnt_n     = cnt;
        illegal_n = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        rd_we     = 1'b0;
        hilo_we   = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_legal(funct)) begin
                        op_n    = funct;
                        cnt_n   = shamt;
                        state_n = S_LOAD;
                    end else begin
                        illegal_n = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                load = 1'b1;
                if (op_r == F_MULTU) begin
                    cnt_n   = MUL_CNT_INIT;
                    state_n = S_MUL;
                end else if (op_r == F_SRL) begin
                    if (cnt == 5'd0) begin
                        state_n = S_WB;
                    end else begin
                        cnt_n   = cnt - 5'd1;
                        state_n = S_SHIFT;
                    end
                end else begin
                    state_n = S_WB;
                end
            end
            S_MUL, S_SHIFT: begin
                step = 1'b1;
                if (cnt == 5'd0) begin
                    state_n = S_WB;
                end else begin
                    cnt_n = cnt - 5'd1;
                end
            end
            S_WB: begin
                done = 1'b1;
                if (op_r == F_MULTU) begin
                    hilo_we = 1'b1;
                end else begin
                    rd_we = 1'b1;
                end
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // The control code tracks the captured op for the whole busy window.
    always_comb begin
        busy = (state != S_IDLE);
        ctl  = busy ? op_r : 6'd0;
    end

    assign illegal = illegal_r;

endmodule
